// File: rtl/axi_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_defs_pkg
// Purpose  : Shared AXI3 encodings for the slave memory: burst types,
//            response codes, write/read engine state encodings and the
//            per-beat address step helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package axi_defs_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Only FIXED and INCR are served; WRAP and the reserved code are errors.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  // Address of the following beat. INCR wraps at 32 bits, no 4 KB check.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == BURST_FIXED) begin
      return addr;
    end
    return addr + (32'd1 << size);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_ram
// Purpose  : Word-addressed 32-bit RAM, one write port with byte enables and
//            one synchronous read port. A read and a write to the same word
//            in one cycle return the old contents.
// Ports    : clk_i              clock
//            we_i[3:0]          byte-lane write enables
//            waddr_i[AW-1:0]    write word index
//            wdata_i[31:0]      write data
//            re_i               read enable (output register loads when 1)
//            raddr_i[AW-1:0]    read word index
//            rdata_o[31:0]      registered read data, held while re_i=0
// Revision : 1.0  initial release
// ============================================================================
module axi_slave_ram #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_slave_memory.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_memory
// Purpose  : AXI3 responder backed by a word-addressed RAM. Independent
//            write (AW/W/B) and read (AR/R) engines, one outstanding burst
//            per direction, FIXED/INCR bursts of 1-16 beats, 32-bit data.
// Ports    : aclk, areset           clock, synchronous active-high reset
//            aw*/awready            write address channel
//            wrdata/wstrb/wlast/wvalid/wready   write data channel
//            bid/bresp/bvalid/bready            write response channel
//            ar*/arready            read address channel
//            rid/rdata/rresp/rlast/rvalid/rready read data channel
//            wid, *lock, *cache, *prot          accepted and ignored
// Revision : 1.0  initial release
// ============================================================================
module axi_slave_memory
  import axi_defs_pkg::*;
#(
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        areset,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awadr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  // Response for a whole burst, decided once at the address phase.
  // Out-of-window beats DECERR ahead of any SLVERR cause.
  function automatic logic [1:0] addr_resp(input logic [31:0] addr,
                                           input logic [2:0]  size,
                                           input logic [1:0]  burst);
    if (addr[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]) begin
      return RESP_DECERR;
    end
    if ((size > 3'd2) || !burst_supported(burst)) begin
      return RESP_SLVERR;
    end
    return RESP_OKAY;
  endfunction

  logic unused_inputs;
  assign unused_inputs = ^{wid, awlock, arlock, awcache, arcache, awprot, arprot};

  // --------------------------------------------------------------------------
  // RAM
  // --------------------------------------------------------------------------
  logic [3:0]        ram_we;
  logic [MEM_AW-1:0] ram_waddr;
  logic              ram_re;
  logic [MEM_AW-1:0] ram_raddr;
  logic [31:0]       ram_rdata;

  axi_slave_ram #(
    .AW (MEM_AW)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (wrdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  wr_state_e   wstate_q, wstate_d;
  logic        awready_q, awready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [3:0]  bid_q, bid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [3:0]  wlen_q, wlen_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic [1:0]  waerr_q, waerr_d;
  logic        wlerr_q, wlerr_d;

  logic w_last_beat;
  logic w_wlast_bad;

  assign w_last_beat = (wcnt_q == wlen_q);
  // wlast must appear on the final beat and nowhere else
  assign w_wlast_bad = (wlast != w_last_beat);

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    waerr_d   = waerr_q;
    wlerr_d   = wlerr_q;
    ram_we    = 4'b0000;
    ram_waddr = waddr_q[MEM_AW+1:2];

    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          wstate_d  = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = awid;
          waddr_d   = awadr;
          wlen_d    = awlen;
          wsize_d   = awsize;
          wburst_d  = awburst;
          wcnt_d    = 4'd0;
          waerr_d   = addr_resp(awadr, awsize, awburst);
          wlerr_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          // errored bursts drain their beats without touching the RAM
          if (waerr_q == RESP_OKAY) begin
            ram_we = wstrb;
          end
          waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
          wcnt_d  = wcnt_q + 4'd1;
          if (w_last_beat) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            if (waerr_q != RESP_OKAY) begin
              bresp_d = waerr_q;
            end else if (wlerr_q || w_wlast_bad) begin
              bresp_d = RESP_SLVERR;
            end else begin
              bresp_d = RESP_OKAY;
            end
          end else begin
            wlerr_d = wlerr_q | w_wlast_bad;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: begin
        wstate_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= 4'd0;
      waddr_q   <= 32'd0;
      wlen_q    <= 4'd0;
      wcnt_q    <= 4'd0;
      wsize_q   <= 3'd0;
      wburst_q  <= BURST_FIXED;
      waerr_q   <= RESP_OKAY;
      wlerr_q   <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      waerr_q   <= waerr_d;
      wlerr_q   <= wlerr_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------
  // raddr_q always holds the address of the beat after the one on the bus,
  // so a handshake can launch the next synchronous RAM read immediately and
  // keep one beat per cycle.
  rd_state_e   rstate_q, rstate_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [3:0]  rid_q, rid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] raddr_q, raddr_d;
  logic [3:0]  rlen_q, rlen_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;

  logic r_last_beat;
  assign r_last_beat = (rcnt_q == rlen_q);

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    ram_re    = 1'b0;
    ram_raddr = raddr_q[MEM_AW+1:2];

    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = arid;
          rresp_d   = addr_resp(araddr, arsize, arburst);
          rlen_d    = arlen;
          rcnt_d    = 4'd0;
          rsize_d   = arsize;
          rburst_d  = arburst;
          ram_re    = 1'b1;
          ram_raddr = araddr[MEM_AW+1:2];
          raddr_d   = next_addr(araddr, arsize, arburst);
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (r_last_beat) begin
            rstate_d  = R_IDLE;
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
          end else begin
            ram_re  = 1'b1;
            rcnt_d  = rcnt_q + 4'd1;
            raddr_d = next_addr(raddr_q, rsize_q, rburst_q);
          end
        end
      end
      default: begin
        rstate_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= 4'd0;
      rresp_q   <= RESP_OKAY;
      raddr_q   <= 32'd0;
      rlen_q    <= 4'd0;
      rcnt_q    <= 4'd0;
      rsize_q   <= 3'd0;
      rburst_q  <= BURST_FIXED;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
    end
  end

  // The RAM output register only loads on a handshake, which keeps rdata
  // stable while the master stalls. Errored bursts and idle cycles show 0.
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rresp   = rvalid_q ? rresp_q : RESP_OKAY;
  assign rlast   = rvalid_q && r_last_beat;
  assign rdata   = (rvalid_q && (rresp_q == RESP_OKAY)) ? ram_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_memory
// Purpose  : Directed self-checking bench for axi_slave_memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_slave_memory;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awadr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wrdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_slave_memory dut (
    .aclk    (aclk),
    .areset  (areset),
    .awid    (awid),
    .awadr   (awadr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awlock  (2'b00),
    .awcache (4'h0),
    .awprot  (3'b000),
    .awvalid (awvalid),
    .awready (awready),
    .wid     (4'h0),
    .wrdata  (wrdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arlock  (2'b00),
    .arcache (4'h0),
    .arprot  (3'b000),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  logic [31:0] wdat [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  logic [31:0] st_data [64];
  int          st_beat [64];
  int          n_st;

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input int lastbeat, input int bdelay,
                          output logic [1:0] resp, output logic [3:0] id_o);
    int n;
    awid = id; awadr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) check("aw_timeout", {31'd0, awready}, 32'd1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wrdata = wdat[i]; wstrb = strb; wlast = (i == lastbeat);
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (!wready) check("w_timeout", {31'd0, wready}, 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) check("b_timeout", {31'd0, bvalid}, 32'd1);
    n = 0;
    for (int i = 0; i < bdelay; i++) begin
      if (bvalid) n++;
      tick();
    end
    if (bdelay > 0) check("b_hold", n, bdelay);
    resp = bresp; id_o = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_drop", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic toggle);
    int n;
    int beat;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) check("ar_timeout", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    check("r_latency", {31'd0, rvalid}, 32'd1);
    beat = 0; n = 0; n_st = 0;
    while (beat <= int'(len) && n < 200) begin
      rready = toggle ? n[0] : 1'b1;
      if (rvalid) begin
        if (rready) begin
          rd_data[beat] = rdata; rd_resp[beat] = rresp; rd_last[beat] = rlast; rd_id = rid;
          beat++;
        end else if (n_st < 64) begin
          st_data[n_st] = rdata; st_beat[n_st] = beat; n_st++;
        end
      end
      tick();
      n++;
    end
    rready = 1'b0;
    if (beat <= int'(len)) check("r_timeout", beat, int'(len) + 1);
    check("r_end_rvalid", {31'd0, rvalid}, 32'd0);
    check("r_end_arready", {31'd0, arready}, 32'd1);
  endtask

  logic [1:0] resp;
  logic [3:0] bid_got;

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    awid = 0; awadr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wrdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    repeat (3) tick();
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    areset = 1'b0;
    tick();
    check("rel_awready", {31'd0, awready}, 32'd1);
    check("rel_arready", {31'd0, arready}, 32'd1);

    // single beat write and read back
    wdat[0] = 32'hDEADBEEF;
    do_write(4'd5, 32'h10, 4'd0, 3'd2, 2'b01, 4'hF, 0, 0, resp, bid_got);
    check("single_bresp", {30'd0, resp}, 32'd0);
    check("single_bid", {28'd0, bid_got}, 32'd5);
    do_read(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, 1'b0);
    check("single_rdata", rd_data[0], 32'hDEADBEEF);
    check("single_rresp", {30'd0, rd_resp[0]}, 32'd0);
    check("single_rlast", {31'd0, rd_last[0]}, 32'd1);
    check("single_rid", {28'd0, rd_id}, 32'd3);

    // INCR 4 beats, delayed bready, toggling rready
    for (int i = 0; i < 4; i++) wdat[i] = i + 1;
    do_write(4'd1, 32'h100, 4'd3, 3'd2, 2'b01, 4'hF, 3, 5, resp, bid_got);
    check("incr_bresp", {30'd0, resp}, 32'd0);
    do_read(4'd2, 32'h100, 4'd3, 3'd2, 2'b01, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_rdata%0d", i), rd_data[i], i + 1);
      check($sformatf("incr_rlast%0d", i), {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("incr_stall_seen", {31'd0, (n_st > 0)}, 32'd1);
    for (int k = 0; k < n_st; k++) check($sformatf("incr_stall%0d", k), st_data[k], st_beat[k] + 1);

    // FIXED burst lands on one word; partial strobe merge
    wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC;
    do_write(4'd0, 32'h40, 4'd2, 3'd2, 2'b00, 4'hF, 2, 0, resp, bid_got);
    check("fixed_bresp", {30'd0, resp}, 32'd0);
    wdat[0] = 32'hFFFFFFFF;
    do_write(4'd0, 32'h44, 4'd0, 3'd2, 2'b01, 4'hF, 0, 0, resp, bid_got);
    wdat[0] = 32'h00001234;
    do_write(4'd0, 32'h44, 4'd0, 3'd2, 2'b01, 4'b0011, 0, 0, resp, bid_got);
    do_read(4'd0, 32'h40, 4'd1, 3'd2, 2'b01, 1'b0);
    check("fixed_word", rd_data[0], 32'hC);
    check("strb_word", rd_data[1], 32'hFFFF1234);

    // out-of-window: DECERR, RAM word 0 (same index) untouched
    wdat[0] = 32'h11111111;
    do_write(4'd0, 32'h0, 4'd0, 3'd2, 2'b01, 4'hF, 0, 0, resp, bid_got);
    wdat[0] = 32'h55;
    do_write(4'd6, 32'h0001_0000, 4'd0, 3'd2, 2'b01, 4'hF, 0, 0, resp, bid_got);
    check("dec_bresp", {30'd0, resp}, 32'd3);
    do_read(4'd0, 32'h0, 4'd0, 3'd2, 2'b01, 1'b0);
    check("dec_ram_kept", rd_data[0], 32'h11111111);
    do_read(4'd0, 32'h0001_0000, 4'd1, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dec_rresp%0d", i), {30'd0, rd_resp[i]}, 32'd3);
      check($sformatf("dec_rdata%0d", i), rd_data[i], 32'd0);
    end
    check("dec_rlast1", {31'd0, rd_last[1]}, 32'd1);

    // unsupported burst / size: SLVERR, no RAM write
    wdat[0] = 32'h22222222;
    do_write(4'd0, 32'h20, 4'd0, 3'd2, 2'b01, 4'hF, 0, 0, resp, bid_got);
    wdat[0] = 32'h99;
    do_write(4'd0, 32'h20, 4'd0, 3'd2, 2'b10, 4'hF, 0, 0, resp, bid_got);
    check("burst_bresp", {30'd0, resp}, 32'd2);
    do_read(4'd0, 32'h20, 4'd0, 3'd2, 2'b01, 1'b0);
    check("burst_ram_kept", rd_data[0], 32'h22222222);
    do_read(4'd0, 32'h20, 4'd0, 3'd3, 2'b01, 1'b0);
    check("size_rresp", {30'd0, rd_resp[0]}, 32'd2);
    check("size_rdata", rd_data[0], 32'd0);

    // early wlast: SLVERR but all beats written
    for (int i = 0; i < 4; i++) wdat[i] = 32'h31 + i;
    do_write(4'd0, 32'h200, 4'd3, 3'd2, 2'b01, 4'hF, 1, 0, resp, bid_got);
    check("wlast_early_bresp", {30'd0, resp}, 32'd2);
    do_read(4'd0, 32'h200, 4'd3, 3'd2, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("wlast_data%0d", i), rd_data[i], 32'h31 + i);
    // missing wlast on the only beat
    wdat[0] = 32'h77;
    do_write(4'd0, 32'h300, 4'd0, 3'd2, 2'b01, 4'hF, -1, 0, resp, bid_got);
    check("wlast_miss_bresp", {30'd0, resp}, 32'd2);
    do_read(4'd0, 32'h300, 4'd0, 3'd2, 2'b01, 1'b0);
    check("wlast_miss_data", rd_data[0], 32'h77);

    // reset in the middle of an 8-beat read
    arid = 4'd7; araddr = 32'h100; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    for (int n = 0; n < 50 && !arready; n++) tick();
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    check("mid_beat0", rdata, 32'd1);
    tick();
    check("mid_beat1", rdata, 32'd2);
    tick();
    check("mid_beat2", rdata, 32'd3);
    check("mid_beat2_valid", {31'd0, rvalid}, 32'd1);
    areset = 1'b1;
    rready = 1'b0;
    tick();
    check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_rst_arready", {31'd0, arready}, 32'd0);
    areset = 1'b0;
    tick();
    check("mid_rel_arready", {31'd0, arready}, 32'd1);
    do_read(4'd9, 32'h10, 4'd0, 3'd2, 2'b01, 1'b0);
    check("post_rst_rdata", rd_data[0], 32'hDEADBEEF);
    check("post_rst_rid", {28'd0, rd_id}, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
